// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path.
//   ps2_state_t    : deframer FSM states
//   PS2_EXT_CODE   : extended-key prefix byte
//   PS2_BREAK_CODE : key-release prefix byte
//   PS2_DATA_BITS  : data bits per frame
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam int         PS2_DATA_BITS  = 8;

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchroniser plus glitch filter for one PS/2 line.
//   i_clk, i_rst : system clock, async active-high reset
//   i_raw        : asynchronous pin
//   o_level      : filtered level; moves only when all FILT_LEN samples agree
//   o_fall       : 1-cycle pulse when o_level goes 1->0
// All state resets to the idle-bus level (1).
module ps2_sync_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_fall
);

    logic [1:0]          sync;
    logic [FILT_LEN-1:0] sr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync    <= '1;
            sr      <= '1;
            o_level <= 1'b1;
            o_fall  <= 1'b0;
        end else begin
            sync   <= {sync[0], i_raw};
            sr     <= {sr[FILT_LEN-2:0], sync[1]};
            o_fall <= 1'b0;
            if (&sr) begin
                o_level <= 1'b1;
            end else if (~|sr) begin
                o_level <= 1'b0;
                o_fall  <= o_level;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: filters the pins, deframes 11-bit frames,
// checks parity/stop/timeout, buffers good bytes in a FIFO and a history
// shift register.
//   i_clk, i_rst    : system clock, async active-high reset
//   i_PS2C, i_PS2D  : raw PS/2 pins
//   o_data/o_valid/i_ready : FIFO head, valid/ready handshake
//   o_history       : last HIST_BYTES good bytes, newest in [7:0]
//   o_parity_err, o_frame_err, o_overflow : 1-cycle error pulses
//   o_busy          : a frame is in progress
// Optional: define PS2_BREAK_DECODE_EN to add o_key_code/o_key_ext/
// o_key_break/o_key_strobe (make/break + extended-key decode).
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILT_LEN       = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int HIST_BYTES     = 3,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_PS2C,
    input  logic                    i_PS2D,
    output logic [7:0]              o_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [8*HIST_BYTES-1:0] o_history,
    output logic                    o_parity_err,
    output logic                    o_frame_err,
    output logic                    o_overflow,
`ifdef PS2_BREAK_DECODE_EN
    output logic [7:0]              o_key_code,
    output logic                    o_key_ext,
    output logic                    o_key_break,
    output logic                    o_key_strobe,
`endif
    output logic                    o_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = 8 * HIST_BYTES;
    localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT_CYCLES);
    localparam logic [2:0]    LAST_BIT = 3'(PS2_DATA_BITS - 1);

    // ---------------- input path ----------------
    logic fall_c, c_lvl_unused;
    logic d_lvl, d_fall_unused;

    ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_filt_c (
        .i_clk(i_clk), .i_rst(i_rst), .i_raw(i_PS2C),
        .o_level(c_lvl_unused), .o_fall(fall_c)
    );

    ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_filt_d (
        .i_clk(i_clk), .i_rst(i_rst), .i_raw(i_PS2D),
        .o_level(d_lvl), .o_fall(d_fall_unused)
    );

    // ---------------- deframer FSM ----------------
    ps2_state_t    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tcnt;
    logic          push_req;
    logic [7:0]    push_byte;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            par          <= 1'b0;
            tcnt         <= '0;
            push_req     <= 1'b0;
            push_byte    <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            push_req     <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;

            // saturating inter-edge timer, only live inside a frame
            if (state == IDLE || fall_c)
                tcnt <= '0;
            else if (tcnt != TMAX)
                tcnt <= tcnt + 1'b1;

            if (state != IDLE && tcnt == TMAX) begin
                o_frame_err <= 1'b1;
                state       <= IDLE;
            end else if (fall_c) begin
                case (state)
                    IDLE: begin
                        // a high sample here is bus noise, not a start bit
                        if (!d_lvl) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg[bit_cnt] <= d_lvl;
                        if (bit_cnt == LAST_BIT)
                            state <= PARITY;
                        else
                            bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY: begin
                        par   <= d_lvl;
                        state <= STOP;
                    end
                    STOP: begin
                        if (!d_lvl)
                            o_frame_err <= 1'b1;
                        else if (^{shreg, par}) begin
                            push_req  <= 1'b1;
                            push_byte <= shreg;
                        end else
                            o_parity_err <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign o_busy = (state != IDLE);

    // ---------------- byte FIFO + history ----------------
    logic [AW:0] wr_ptr, rd_ptr;
    logic [7:0]  mem [FIFO_DEPTH];
    logic        full, pop;

    assign o_valid = (wr_ptr != rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = o_valid & i_ready;
    assign o_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_overflow <= 1'b0;
            o_history  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            // a pop in the same cycle frees the slot, so full+pop still writes
            o_overflow <= push_req & full & ~pop;
            if (push_req && (!full || pop)) begin
                mem[wr_ptr[AW-1:0]] <= push_byte;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_req)
                o_history <= (o_history << 8) | HW'(push_byte);
        end
    end

`ifdef PS2_BREAK_DECODE_EN
    // ---------------- make/break decode ----------------
    logic ext_pend, brk_pend;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ext_pend     <= 1'b0;
            brk_pend     <= 1'b0;
            o_key_code   <= '0;
            o_key_ext    <= 1'b0;
            o_key_break  <= 1'b0;
            o_key_strobe <= 1'b0;
        end else begin
            o_key_strobe <= 1'b0;
            if (push_req) begin
                if (push_byte == PS2_EXT_CODE)
                    ext_pend <= 1'b1;
                else if (push_byte == PS2_BREAK_CODE)
                    brk_pend <= 1'b1;
                else begin
                    o_key_code   <= push_byte;
                    o_key_ext    <= ext_pend;
                    o_key_break  <= brk_pend;
                    o_key_strobe <= 1'b1;
                    ext_pend     <= 1'b0;
                    brk_pend     <= 1'b0;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: bit-bangs PS/2 frames on the pins and
// checks bytes, pulses, history and busy against hand-computed values.
// Define PS2_BREAK_DECODE_EN to also exercise the key decoder.
module tb_ps2_rx_frame;

    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2c = 1'b1;
    logic        ps2d = 1'b1;
    logic        ready = 1'b1;
    logic [7:0]  o_data;
    logic        o_valid;
    logic [23:0] o_history;
    logic        o_parity_err, o_frame_err, o_overflow, o_busy;
`ifdef PS2_BREAK_DECODE_EN
    logic [7:0]  key_code;
    logic        key_ext, key_break, key_strobe;
`endif

    always #5 clk = ~clk;

    ps2_rx_frame #(
        .FILT_LEN(8), .FIFO_DEPTH(4), .HIST_BYTES(3), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_PS2C(ps2c), .i_PS2D(ps2d),
        .o_data(o_data), .o_valid(o_valid), .i_ready(ready),
        .o_history(o_history), .o_parity_err(o_parity_err),
        .o_frame_err(o_frame_err), .o_overflow(o_overflow),
`ifdef PS2_BREAK_DECODE_EN
        .o_key_code(key_code), .o_key_ext(key_ext),
        .o_key_break(key_break), .o_key_strobe(key_strobe),
`endif
        .o_busy(o_busy)
    );

    // event counters sampled on the falling edge
    int n_perr = 0, n_ferr = 0, n_ovf = 0, n_vld = 0, rx_cnt = 0;
    logic [7:0] rx_mem [64];
`ifdef PS2_BREAK_DECODE_EN
    int n_ks = 0;
    logic [7:0] ks_code;
    logic ks_ext, ks_brk;
`endif

    always @(negedge clk) begin
        if (o_parity_err) n_perr++;
        if (o_frame_err)  n_ferr++;
        if (o_overflow)   n_ovf++;
        if (o_valid)      n_vld++;
        if (o_valid && ready) begin
            rx_mem[rx_cnt] = o_data;
            rx_cnt++;
        end
`ifdef PS2_BREAK_DECODE_EN
        if (key_strobe) begin
            n_ks++;
            ks_code = key_code;
            ks_ext  = key_ext;
            ks_brk  = key_break;
        end
`endif
    end

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // frame = {stop, parity, data, start}; parity made odd, optionally inverted
    function automatic logic [10:0] frame(input logic [7:0] b, input logic pflip, input logic stop);
        return {stop, (~^b) ^ pflip, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ps2d = bits[i];
            repeat (20) @(negedge clk);
            ps2c = 1'b0;
            repeat (20) @(negedge clk);
            ps2c = 1'b1;
        end
    endtask

    task automatic settle();
        repeat (30) @(negedge clk);
        ps2d = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(frame(b, 1'b0, 1'b1), 11);
        settle();
    endtask

    task automatic glitch_c();
        @(negedge clk) ps2c = 1'b0;
        repeat (7) @(negedge clk);
        ps2c = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int bp, bf, bv, br, bo;
        logic [10:0] fr;

        // reset state
        repeat (5) @(negedge clk);
        check("rst_valid", {31'd0, o_valid}, 0);
        check("rst_busy", {31'd0, o_busy}, 0);
        check("rst_hist", {8'd0, o_history}, 0);
        check("rst_data", {24'd0, o_data}, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 1: good frame 0x1C
        bp = n_perr; bf = n_ferr; bv = n_vld; br = rx_cnt;
        send_byte(8'h1C);
        check("t1_rxcnt", rx_cnt - br, 1);
        check("t1_byte", {24'd0, rx_mem[br]}, 32'h1C);
        check("t1_valid_cycles", n_vld - bv, 1);
        check("t1_hist", {24'd0, o_history[7:0]}, 32'h1C);
        check("t1_noerr", (n_perr - bp) + (n_ferr - bf), 0);

        // 2: bad parity
        bp = n_perr; bv = n_vld;
        send_bits(frame(8'h1C, 1'b1, 1'b1), 11);
        settle();
        check("t2_perr", n_perr - bp, 1);
        check("t2_novalid", n_vld - bv, 0);
        check("t2_hist", {8'd0, o_history}, 32'h00001C);

        // 3: bad stop, timeout, then recovery
        bf = n_ferr; bp = n_perr; bv = n_vld;
        send_bits(frame(8'h1C, 1'b0, 1'b0), 11);
        settle();
        check("t3_stop_ferr", n_ferr - bf, 1);
        check("t3_stop_perr", n_perr - bp, 0);
        check("t3_stop_nopush", n_vld - bv, 0);
        bf = n_ferr;
        send_bits(frame(8'h1C, 1'b0, 1'b1), 4);
        @(negedge clk) ps2d = 1'b1;
        repeat (5) @(negedge clk);
        check("t3_busy_mid", {31'd0, o_busy}, 1);
        repeat (TMO + 50) @(negedge clk);
        check("t3_tmo_ferr", n_ferr - bf, 1);
        check("t3_tmo_busy", {31'd0, o_busy}, 0);
        br = rx_cnt;
        send_byte(8'h32);
        check("t3_rx32", {24'd0, rx_mem[br]}, 32'h32);

        // 4: overflow with consumer stalled
        ready = 1'b0;
        bo = n_ovf; br = rx_cnt;
        for (int k = 1; k <= 4; k++) send_byte(8'(k));
        check("t4_noovf_4", n_ovf - bo, 0);
        send_byte(8'h05);
        check("t4_ovf_5", n_ovf - bo, 1);
        check("t4_hist", {8'd0, o_history}, 32'h030405);
        @(negedge clk) ready = 1'b1;
        repeat (10) @(negedge clk);
        check("t4_popcnt", rx_cnt - br, 4);
        for (int k = 0; k < 4; k++) check("t4_pop", {24'd0, rx_mem[br + k]}, k + 1);

        // 5: sub-filter glitches, idle and mid-frame
        bp = n_perr; bf = n_ferr; br = rx_cnt;
        glitch_c();
        check("t5_idle_glitch_busy", {31'd0, o_busy}, 0);
        fr = frame(8'h1C, 1'b0, 1'b1);
        send_bits(fr, 3);
        glitch_c();
        check("t5_mid_glitch_busy", {31'd0, o_busy}, 1);
        send_bits(fr >> 3, 8);
        settle();
        check("t5_rxcnt", rx_cnt - br, 1);
        check("t5_byte", {24'd0, rx_mem[br]}, 32'h1C);
        check("t5_noerr", (n_perr - bp) + (n_ferr - bf), 0);

        // reset mid-frame
        send_bits(frame(8'h5A, 1'b0, 1'b1), 4);
        @(negedge clk) rst = 1'b1;
        ps2d = 1'b1;
        @(negedge clk);
        check("t5_rst_busy", {31'd0, o_busy}, 0);
        check("t5_rst_hist", {8'd0, o_history}, 0);
        check("t5_rst_valid", {31'd0, o_valid}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("t5_rst_noerr", (n_perr - bp) + (n_ferr - bf), 0);
        br = rx_cnt;
        send_byte(8'h5A);
        check("t5_post_rst_rx", {24'd0, rx_mem[br]}, 32'h5A);
        check("t5_post_rst_hist", {8'd0, o_history}, 32'h00005A);

`ifdef PS2_BREAK_DECODE_EN
        // 6: make/break decode
        begin
            int bk;
            bk = n_ks;
            send_byte(8'hE0);
            send_byte(8'hF0);
            check("t6_no_strobe_prefix", n_ks - bk, 0);
            send_byte(8'h75);
            check("t6_strobes", n_ks - bk, 1);
            check("t6_code", {24'd0, ks_code}, 32'h75);
            check("t6_ext", {31'd0, ks_ext}, 1);
            check("t6_brk", {31'd0, ks_brk}, 1);
            send_byte(8'h1C);
            check("t6_strobes2", n_ks - bk, 2);
            check("t6_code2", {24'd0, ks_code}, 32'h1C);
            check("t6_ext2", {31'd0, ks_ext}, 0);
            check("t6_brk2", {31'd0, ks_brk}, 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
Parametrised PS/2 device-to-host receiver, the successor to the single-register scan-code capture block. Filters and edge-detects PS2C/PS2D, deframes the 11-bit frame (start, 8 data LSB-first, odd parity, stop) and checks parity, stop bit and inter-bit timeout. Good bytes are buffered in a valid/ready FIFO and shifted into a multi-byte history register. Sits between the board PS/2 pins and keyboard decode/display logic.

Parameters:
FILT_LEN, 8, filter depth in i_clk cycles (>=2); the filtered level changes only when all FILT_LEN samples agree
FIFO_DEPTH, 4, byte FIFO entries; power of 2, >=2
HIST_BYTES, 3, bytes held in o_history
TIMEOUT_CYCLES, 100000, i_clk cycles allowed between PS2C falling edges inside a frame

Ports:
i_clk  in  1  system clock; all logic on its rising edge
i_rst  in  1  reset, asynchronous, active-high
i_PS2C  in  1  raw PS/2 clock, asynchronous
i_PS2D  in  1  raw PS/2 data, asynchronous
o_data  out  8  FIFO head byte
o_valid  out  1  FIFO not empty
i_ready  in  1  consumer accepts o_data when o_valid&i_ready
o_history  out  8*HIST_BYTES  last good bytes; newest in [7:0]
o_parity_err  out  1  1-cycle pulse, parity mismatch
o_frame_err  out  1  1-cycle pulse, bad stop bit or timeout
o_overflow  out  1  1-cycle pulse, good byte dropped because FIFO full
o_busy  out  1  FSM not in IDLE

Behaviour:
- Reset: FSM IDLE; FIFO empty; o_data, o_history and all pulses 0; filtered PS2C/PS2D and filter shift registers 1 (idle bus).
- Input path: 2-FF synchroniser, then FILT_LEN shift register; the filtered level holds until all FILT_LEN samples agree. fall_c is a 1-cycle pulse on a 1->0 transition of filtered PS2C. All sampling of PS2D happens on fall_c only.
- FSM (one transition per fall_c):
  - IDLE: fall_c with D=0 -> DATA, bit count=0. fall_c with D=1 is ignored and no error is flagged.
  - DATA: shift D into bit[count], LSB first; after the 8th bit -> PARITY.
  - PARITY: store D -> STOP.
  - STOP: if D=1 and ^{data,parity}=1, push the byte and update history. If parity is bad, pulse o_parity_err. If stop=0, pulse o_frame_err; this takes priority when both are bad. -> IDLE.
- Timeout: counter clears on every fall_c and while in IDLE. When it reaches TIMEOUT_CYCLES outside IDLE: discard the partial byte, pulse o_frame_err, -> IDLE. The counter saturates and does not wrap.
- Latency: the byte is written on the cycle after the STOP fall_c; o_valid and o_history update on the following edge.
- FIFO: pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. o_data is the registered head.
  - Pop when o_valid&i_ready.
  - Push when full without a simultaneous pop: the byte is dropped and o_overflow pulses.
  - Push and pop in the same cycle while full: both succeed.
  - Pop while empty: no effect.
- History: on every good byte, o_history <= {o_history[8*HIST_BYTES-9:0], byte}. It updates even when the FIFO overflows.
- i_rst mid-frame: returns immediately to the reset state. The partial frame is lost and no error pulse is generated.

Optional Feature:
PS2_BREAK_DECODE_EN: adds outputs o_key_code[7:0], o_key_ext, o_key_break and o_key_strobe.
- Prefix 0xE0 sets a pending ext flag; 0xF0 sets a pending break flag.
- Any other good byte: o_key_code<=byte, ext/break <= pending flags, 1-cycle o_key_strobe, then both pending flags clear.
- Decode taps good bytes, not FIFO pops. Reset clears all of these to 0.
- Without the macro, these ports and the decode logic are absent.

Decomposition:
- Package ps2_pkg: FSM state enum (IDLE, DATA, PARITY, STOP), PS2_EXT_CODE=8'hE0, PS2_BREAK_CODE=8'hF0, frame bit-count constant 8.
- Sub-module ps2_sync_filter (synchroniser, FILT_LEN filter, fall pulse): instantiated for PS2C and PS2D.
- FIFO stays inline.

Test Plan:
1. Frame for 0x1C (start 0, data LSB-first, parity 0, stop 1), i_ready=1 -> o_valid for exactly 1 cycle with o_data=8'h1C; o_history[7:0]=8'h1C; no error pulses.
2. Same frame with parity=1 -> one o_parity_err pulse; o_valid stays 0; o_history unchanged.
3. Frame 0x1C with stop=0 -> one o_frame_err pulse and no push. Next a start + 3 bits, then PS2C held high for TIMEOUT_CYCLES -> o_frame_err pulse, o_busy falls. Then frame 0x32 -> received as 8'h32.
4. i_ready=0, send 0x01..0x05 with FIFO_DEPTH=4 -> o_overflow pulses only on 0x05. Pops return 01,02,03,04. o_history (HIST_BYTES=3) = 24'h030405.
5. PS2C low pulses of FILT_LEN-1 cycles while idle and mid-frame -> no fall_c and no state change. Assert i_rst mid-frame -> outputs at reset values; a following full frame is received correctly.
6. With PS2_BREAK_DECODE_EN, send E0,F0,75 -> single o_key_strobe with code=8'h75, ext=1, break=1. Then 1C -> code=8'h1C, ext=0, break=0.
